// File: rtl/des_key_schedule.sv
// DES round-key generator: derives K1..K16 (or K16..K1 for decryption) from a 64-bit key,
// one subkey per accepted handshake, and wipes all key material when the run finishes.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  // Tables use FIPS 46-3 numbering: bit 1 is the MSB of the source vector.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Bit (r-1) set means round r rotates by two positions instead of one.
  localparam logic [15:0] SHIFT_TWO = 16'h7EFC;

  logic [0:0]  stateReg, stateNext;
  logic [27:0] cReg, cNext;
  logic [27:0] dReg, dNext;
  logic        decReg, decNext;
  logic [47:0] subkeyReg, subkeyNext;
  logic        validReg, validNext;
  logic [3:0]  idxReg, idxNext;
  logic        busyReg, busyNext;
  logic        doneReg, doneNext;

  logic [55:0] pc1Key;
  logic [55:0] cdNext;
  logic [47:0] pc2Out;
  logic        unusedParity;

  function automatic logic [27:0] rotL(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotR(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1Key[55-gi] = key_in[64-PC1[gi]];
    end
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign pc2Out[47-gi] = cdNext[56-PC2[gi]];
    end
  endgenerate

  assign unusedParity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                          key_in[24], key_in[16], key_in[8], key_in[0]};

  // The subkey register always mirrors PC-2 of the C/D registers, so zeroizing C/D
  // also zeroizes the subkey and a stalled round simply recomputes the same value.
  assign cdNext     = {cNext, dNext};
  assign subkeyNext = pc2Out;

  always_comb begin
    stateNext = stateReg;
    cNext     = cReg;
    dNext     = dReg;
    decNext   = decReg;
    validNext = validReg;
    idxNext   = idxReg;
    busyNext  = busyReg;
    doneNext  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start && !doneReg) begin
          stateNext = EMIT;
          decNext   = decrypt;
          validNext = 1'b1;
          idxNext   = 4'd0;
          busyNext  = 1'b1;
          // Decryption starts at K16, whose C/D equal C0/D0 (total rotation is 28).
          cNext     = decrypt ? pc1Key[55:28] : rotL(pc1Key[55:28], 1'b0);
          dNext     = decrypt ? pc1Key[27:0]  : rotL(pc1Key[27:0], 1'b0);
        end
      end
      EMIT: begin
        if (subkey_ready) begin
          if (idxReg == 4'd15) begin
            stateNext = IDLE;
            cNext     = '0;
            dNext     = '0;
            validNext = 1'b0;
            idxNext   = 4'd0;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end else begin
            idxNext = idxReg + 4'd1;
            if (decReg) begin
              cNext = rotR(cReg, SHIFT_TWO[4'd15 - idxReg]);
              dNext = rotR(dReg, SHIFT_TWO[4'd15 - idxReg]);
            end else begin
              cNext = rotL(cReg, SHIFT_TWO[idxReg + 4'd1]);
              dNext = rotL(dReg, SHIFT_TWO[idxReg + 4'd1]);
            end
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      cReg      <= '0;
      dReg      <= '0;
      decReg    <= 1'b0;
      subkeyReg <= '0;
      validReg  <= 1'b0;
      idxReg    <= 4'd0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      cReg      <= cNext;
      dReg      <= dNext;
      decReg    <= decNext;
      subkeyReg <= subkeyNext;
      validReg  <= validNext;
      idxReg    <= idxNext;
      busyReg   <= busyNext;
      doneReg   <= doneNext;
    end
  end

  assign subkey       = subkeyReg;
  assign subkey_valid = validReg;
  assign round_idx    = idxReg;
  assign busy         = busyReg;
  assign done         = doneReg;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: a reference model computes each DES round key directly
// from the key and cumulative rotation count, and is checked against the DUT every cycle.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_in),
    .subkey_ready(subkey_ready), .subkey(subkey), .subkey_valid(subkey_valid),
    .round_idx(round_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

  localparam int TB_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int TB_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int nCmp = 0;
  int nFail = 0;

  // Model state
  bit          mValid = 1'b0;
  bit          mDone = 1'b0;
  bit          mBusy = 1'b0;
  int          mIdx = 0;
  logic [47:0] mKeys [16];

  logic [47:0] logArr [32];
  logic [47:0] encLog [16];
  int          logCnt = 0;
  int          doneCnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round r key: rotate C0/D0 left by the cumulative shift count, then apply PC-2.
  function automatic logic [47:0] refSubkey(input logic [63:0] k, input int r);
    logic        b0 [56];
    logic        cdr [56];
    logic [47:0] res;
    int          tot;
    for (int i = 0; i < 56; i++) b0[i] = k[64 - TB_PC1[i]];
    tot = 0;
    for (int i = 0; i < r; i++) tot += SHIFTS[i];
    for (int i = 0; i < 28; i++) begin
      cdr[i]      = b0[(i + tot) % 28];
      cdr[28 + i] = b0[28 + (i + tot) % 28];
    end
    for (int j = 0; j < 48; j++) res[47 - j] = cdr[TB_PC2[j] - 1];
    return res;
  endfunction

  task automatic modelReset();
    mValid = 1'b0;
    mDone  = 1'b0;
    mBusy  = 1'b0;
    mIdx   = 0;
  endtask

  task automatic modelStep();
    bit wasDone;
    wasDone = mDone;
    if (!rst_n) begin
      modelReset();
    end else begin
      mDone = 1'b0;
      if (mValid) begin
        if (subkey_ready) begin
          if (mIdx == 15) begin
            mValid = 1'b0;
            mBusy  = 1'b0;
            mDone  = 1'b1;
            mIdx   = 0;
          end else begin
            mIdx++;
          end
        end
      end else if (start && !wasDone) begin
        for (int r = 0; r < 16; r++)
          mKeys[r] = decrypt ? refSubkey(key_in, 16 - r) : refSubkey(key_in, r + 1);
        mValid = 1'b1;
        mBusy  = 1'b1;
        mIdx   = 0;
      end
    end
  endtask

  // Compare process: step the model on each rising edge, check outputs on the falling edge.
  always begin
    @(posedge clk);
    if (subkey_valid && subkey_ready) begin
      if (logCnt < 32) logArr[logCnt] = subkey;
      logCnt++;
    end
    modelStep();
    @(negedge clk);
    if (!rst_n) modelReset();
    check("valid", subkey_valid, mValid);
    check("subkey", subkey, mValid ? mKeys[mIdx] : 48'h0);
    check("round_idx", round_idx, mIdx);
    check("busy", busy, mBusy);
    check("done", done, mDone);
    if (done) doneCnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic startRun(input logic [63:0] k, input logic dec);
    tick();
    key_in  = k;
    decrypt = dec;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("lat_valid", subkey_valid, 1'b1);
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    if (!seen) check("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic waitIdx(input logic [3:0] n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (subkey_valid && round_idx == n) seen = 1'b1;
      else tick();
    end
    if (!seen) check("idx_timeout", 1'b0, 1'b1);
  endtask

  task automatic checkAgainstEnc(input string name);
    check({name, "_count"}, logCnt, 16);
    for (int i = 0; i < 16; i++) check(name, logArr[i], encLog[i]);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1; key_in = KEY;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", subkey_valid, 1'b0);
    check("rst_subkey", subkey, 48'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("ref_k1", refSubkey(KEY, 1), K1);
    check("ref_k2", refSubkey(KEY, 2), K2);
    check("ref_k16", refSubkey(KEY, 16), K16);
    tick();
    rst_n = 1'b1;

    // Encrypt order, no backpressure
    logCnt = 0; doneCnt = 0;
    startRun(KEY, 1'b0);
    check("enc_first", subkey, K1);
    tick();
    check("enc_second", subkey, K2);
    waitDone();
    check("enc_count", logCnt, 16);
    check("enc_k1", logArr[0], K1);
    check("enc_k2", logArr[1], K2);
    check("enc_k16", logArr[15], K16);
    check("enc_done_cnt", doneCnt, 1);
    for (int i = 0; i < 16; i++) encLog[i] = logArr[i];
    tick();

    // Decrypt order is the exact reverse
    logCnt = 0;
    startRun(KEY, 1'b1);
    check("dec_first", subkey, K16);
    waitDone();
    check("dec_count", logCnt, 16);
    check("dec_last", logArr[15], K1);
    for (int i = 0; i < 16; i++) check("dec_order", logArr[i], encLog[15 - i]);
    tick();

    // Backpressure for three cycles at round 5
    logCnt = 0;
    startRun(KEY, 1'b0);
    waitIdx(4'd5);
    subkey_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_idx", round_idx, 4'd5);
      check("bp_subkey", subkey, K1 ^ K1 ^ encLog[5]);
    end
    subkey_ready = 1'b1;
    waitDone();
    checkAgainstEnc("bp_seq");
    tick();

    // Start and key changes mid-run are ignored; start in the done cycle is ignored
    logCnt = 0; doneCnt = 0;
    startRun(KEY, 1'b0);
    waitIdx(4'd7);
    start = 1'b1; key_in = ~KEY; decrypt = 1'b1;
    tick();
    start = 1'b0; key_in = {$urandom, $urandom};
    waitDone();
    checkAgainstEnc("midstart_seq");
    check("midstart_done_cnt", doneCnt, 1);
    start = 1'b1; key_in = KEY; decrypt = 1'b0;
    tick();
    check("donecyc_ignored", subkey_valid, 1'b0);
    tick();
    check("after_done_start", subkey_valid, 1'b1);
    check("after_done_k1", subkey, K1);
    start = 1'b0;
    waitDone();
    tick();

    // Reset mid-run aborts at once
    startRun(KEY, 1'b0);
    waitIdx(4'd9);
    rst_n = 1'b0;
    #1;
    check("abort_valid", subkey_valid, 1'b0);
    check("abort_subkey", subkey, 48'h0);
    check("abort_idx", round_idx, 4'd0);
    check("abort_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_abort_idle", subkey_valid, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; start = 1'b1; key_in = KEY; decrypt = 1'b0;
    tick();
    start = 1'b0;
    check("rst_release_start", subkey_valid, 1'b1);
    check("rst_release_k1", subkey, K1);
    waitDone();
    tick();

    // Parity bits do not affect the schedule
    logCnt = 0;
    startRun(KEY ^ 64'h0101010101010101, 1'b0);
    waitDone();
    checkAgainstEnc("parity_seq");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin a 16-round schedule; sampled only in IDLE.
REQ-005 decrypt  input  1  captured with start; 0 = emit K1..K16, 1 = emit K16..K1.
REQ-006 key_in  input  64  DES key; key_in[63] = FIPS 46-3 bit 1; parity bits ignored.
REQ-007 subkey_ready  input  1  downstream (48-bit endian swap stage) accepts the current subkey.
REQ-008 subkey  output  48  current round subkey; subkey[47] = PC-2 output bit 1.
REQ-009 subkey_valid  output  1  subkey holds a valid round key.
REQ-010 round_idx  output  4  emission index 0..15 of the subkey on the output.
REQ-011 busy  output  1  high from start acceptance until the cycle after the final handshake.
REQ-012 done  output  1  one-cycle pulse after the 16th subkey is accepted.

Function
REQ-013 States SHALL be IDLE and EMIT only.
REQ-014 IDLE: start=1 at an edge SHALL load C/D = PC-1(key_in) with round-1 rotation applied, latch decrypt, and set subkey = PC-2(C,D), subkey_valid=1, round_idx=0, busy=1, state=EMIT.
REQ-015 The subkey, subkey_valid and round_idx outputs SHALL be driven from registers, giving 1-cycle latency from start to the first subkey_valid.
REQ-016 Encrypt rotation: C and D each rotate left by s_r, s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for r = 1..16.
REQ-017 Decrypt rotation: round 1 applies no rotation (C16 = C0); round j >= 2 rotates right by s_(18-j).
REQ-018 EMIT, subkey_valid & subkey_ready with round_idx < 15: next edge advances C/D, reloads subkey and increments round_idx; there SHALL be no bubble between rounds.
REQ-019 EMIT, subkey_valid=1 & subkey_ready=0: subkey, round_idx and C/D SHALL hold unchanged.
REQ-020 EMIT, handshake with round_idx = 15: next edge clears subkey_valid, pulses done for one cycle, returns to IDLE, and clears busy.
REQ-021 Returning to IDLE SHALL zeroize C, D and subkey, so no key material is retained.
REQ-022 start asserted while busy=1, including the done cycle, SHALL be ignored.
REQ-023 key_in and decrypt SHALL be sampled only on the accepting edge; later changes SHALL have no effect on the run.
REQ-024 A new start SHALL be accepted no earlier than the cycle after done.

Reset
REQ-025 rst_n low SHALL force state=IDLE, C=D=0, subkey=0, subkey_valid=0, round_idx=0, busy=0, done=0, and latched decrypt=0.
REQ-026 Reset asserted during EMIT SHALL abort the run immediately, and no further subkeys SHALL be emitted after deassertion until a new start.
REQ-027 Reset deassertion SHALL take effect at the next rising edge; start in that cycle SHALL be honoured.

Verification
REQ-028 key_in=133457799BBCDFF1, decrypt=0, subkey_ready=1 -> K1=1B02EFFC7072 one cycle after start, K2=79AED9DBC9E5 next cycle, 16th subkey=CB3D8B0E17F5, done pulse one cycle after it.
REQ-029 Same key, decrypt=1 -> first subkey=CB3D8B0E17F5, last=1B02EFFC7072, and emission order is the exact reverse of REQ-028.
REQ-030 Backpressure: deassert subkey_ready for 3 cycles at round_idx=5 -> subkey and round_idx held stable for those cycles, with no dropped or duplicated subkey.
REQ-031 Pulse start at round_idx=7 and toggle key_in -> run completes unchanged with 16 subkeys and done once.
REQ-032 Assert rst_n low at round_idx=9 -> outputs zero the same cycle, and no subkey_valid until the next start.
REQ-033 Flip only the parity bits of key_in (bits 8,16..64) -> all 16 subkeys identical to REQ-028.
